// File: rtl/a3_cpu_pkg.sv
// Shared types for the execution domain: opcodes, register roles, result payload.
package a3_cpu_pkg;

  // Widest datapath / register-index the result payload can carry.
  localparam int unsigned MAX_XLEN = 64;
  localparam int unsigned MAX_RW   = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MOV = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] data;
    logic [MAX_RW-1:0]   rd;
    logic                zero;
    logic                carry;
    logic                err;
  } res_t;

  // Frame pointer lives just below the stack pointer at the top of the file.
  function automatic int unsigned reg_fp(input int unsigned nregs);
    return nregs - 2;
  endfunction

  function automatic int unsigned reg_sp(input int unsigned nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/exec_domain_if.sv
// Issue / result bus of the execution domain.
interface exec_domain_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 18
);
  localparam int unsigned RW = $clog2(NREGS);

  logic            issue_valid;
  logic            issue_ready;
  logic [3:0]      issue_op;
  logic [RW-1:0]   issue_rd;
  logic [RW-1:0]   issue_rs1;
  logic [RW-1:0]   issue_rs2;
  logic            issue_use_imm;
  logic [XLEN-1:0] issue_imm;

  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic [RW-1:0]   res_rd;
  logic            res_zero;
  logic            res_carry;
  logic            res_err;

  modport master (
    output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_use_imm, issue_imm,
    input  issue_ready, res_valid, res_data, res_rd, res_zero, res_carry, res_err
  );

  modport slave (
    input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_use_imm, issue_imm,
    output issue_ready, res_valid, res_data, res_rd, res_zero, res_carry, res_err
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative unsigned multiplier: one shift-add step per cycle, XLEN cycles busy.
module mul_iter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy_c,
  output logic            done_c,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e          state_q, state_d;
  logic            load, step, last;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]   cnt_q;

  // Bit 0 is folded in at load, so the product is complete when the counter reaches XLEN-1.
  assign last    = (cnt_q == CW'(XLEN - 1));
  assign product = acc_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        busy_c = 1'b1;
        if (last) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/exec_domain.sv
// CPU execution domain: regfile, 1-deep EX stage with bypass, iterative MUL. XLEN up to 64.
module exec_domain
  import a3_cpu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 18,
  parameter logic [63:0] SP_RESET = 64'h0,
  localparam int unsigned RW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  exec_domain_if.slave    bus,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);

  logic [XLEN-1:0] regs [NREGS];
  res_t            ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d, ex_fwd;
  logic [RW-1:0]   mul_rd_q;
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;
  logic            accept, bad;
  logic [XLEN-1:0] op0, op1, alu_data;
  logic            alu_carry;
  logic [XLEN:0]   sum, diff;

  function automatic logic idx_bad(input logic [RW-1:0] idx);
    return 32'(idx) >= NREGS;
  endfunction

  assign bus.issue_ready = !mul_busy;
  assign busy            = mul_busy;
  assign accept          = bus.issue_valid && bus.issue_ready;
  assign ex_fwd          = ex_valid_q && !ex_q.err;
  assign bad             = (bus.issue_op > 4'd8) || idx_bad(bus.issue_rd) || idx_bad(bus.issue_rs1)
                           || (!bus.issue_use_imm && idx_bad(bus.issue_rs2));
  assign mul_start       = accept && !bad && (op_e'(bus.issue_op) == OP_MUL);
  assign ex_valid_d      = accept && !mul_start;

  // Operand fetch; the EX result is not yet in the regfile, so forward it.
  always_comb begin
    op0 = '0;
    op1 = bus.issue_imm;
    if (!idx_bad(bus.issue_rs1)) op0 = regs[bus.issue_rs1];
    if (ex_fwd && ex_q.rd == MAX_RW'(bus.issue_rs1)) op0 = ex_q.data[XLEN-1:0];
    if (!bus.issue_use_imm) begin
      op1 = '0;
      if (!idx_bad(bus.issue_rs2)) op1 = regs[bus.issue_rs2];
      if (ex_fwd && ex_q.rd == MAX_RW'(bus.issue_rs2)) op1 = ex_q.data[XLEN-1:0];
    end
  end

  // Single-cycle ALU; result is captured into EX at the accept edge.
  always_comb begin
    alu_data  = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, op0} + {1'b0, op1};
    diff      = {1'b0, op0} - {1'b0, op1};
    case (op_e'(bus.issue_op))
      OP_ADD: begin alu_data = sum[XLEN-1:0];  alu_carry = sum[XLEN];  end
      OP_SUB: begin alu_data = diff[XLEN-1:0]; alu_carry = diff[XLEN]; end
      OP_AND: alu_data = op0 & op1;
      OP_OR:  alu_data = op0 | op1;
      OP_XOR: alu_data = op0 ^ op1;
      OP_SHL: alu_data = op0 << op1[SW-1:0];
      OP_SHR: alu_data = op0 >> op1[SW-1:0];
      OP_MOV: alu_data = op1;
      default: ;
    endcase
    if (bad) begin
      alu_data  = '0;
      alu_carry = 1'b0;
    end
    ex_d       = '0;
    ex_d.data  = MAX_XLEN'(alu_data);
    ex_d.rd    = MAX_RW'(bus.issue_rd);
    ex_d.zero  = (alu_data == '0);
    ex_d.carry = alu_carry;
    ex_d.err   = bad;
  end

  // EX stage register and MUL destination capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      mul_rd_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (ex_valid_d) ex_q     <= ex_d;
      if (mul_start)  mul_rd_q <= bus.issue_rd;
    end
  end

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op0),
    .b       (op1),
    .busy_c  (mul_busy),
    .done_c  (mul_done),
    .product (mul_product)
  );

  // Result strobe: EX and MUL completions never coincide since issue stalls while MUL runs.
  always_comb begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.res_rd    = '0;
    bus.res_zero  = 1'b0;
    bus.res_carry = 1'b0;
    bus.res_err   = 1'b0;
    if (ex_valid_q) begin
      bus.res_valid = 1'b1;
      bus.res_data  = ex_q.data[XLEN-1:0];
      bus.res_rd    = ex_q.rd[RW-1:0];
      bus.res_zero  = ex_q.zero;
      bus.res_carry = ex_q.carry;
      bus.res_err   = ex_q.err;
    end else if (mul_done) begin
      bus.res_valid = 1'b1;
      bus.res_data  = mul_product;
      bus.res_rd    = mul_rd_q;
      bus.res_zero  = (mul_product == '0);
    end
  end

  // Architectural register file with writeback from EX and MUL.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= (i == reg_sp(NREGS)) ? XLEN'(SP_RESET) : '0;
    end else begin
      if (ex_fwd)   regs[ex_q.rd[RW-1:0]] <= ex_q.data[XLEN-1:0];
      if (mul_done) regs[mul_rd_q]        <= mul_product;
    end
  end

  // Debug port sees the committed regfile only.
  always_comb begin
    dbg_data = '0;
    if (!idx_bad(dbg_addr)) dbg_data = regs[dbg_addr];
  end

endmodule
